// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: word size, bubble instruction,
// fetch FSM states and the IF/ID register layout.
package fetch_stage_pkg;

  localparam int WORD_SIZE = 32;
  localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetchState_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] pcPlus4;
    logic                 valid;
  } ifIdReg_t;

  localparam ifIdReg_t IFID_BUBBLE = '{
    instr:   NOP_INSTR,
    pc:      32'h0000_0000,
    pcPlus4: 32'h0000_0000,
    valid:   1'b0
  };

  function automatic logic [WORD_SIZE-1:0] alignWord(input logic [WORD_SIZE-1:0] addr);
    return {addr[WORD_SIZE-1:2], 2'b00};
  endfunction

  function automatic logic [WORD_SIZE-1:0] nextWord(input logic [WORD_SIZE-1:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, req/ack handshake with instruction memory, response
// buffer for stalled decode, and the IF/ID register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [WORD_SIZE-1:0] PCTargetE,
  output logic                 ImemReq,
  output logic [WORD_SIZE-1:0] ImemAddr,
  input  logic                 ImemAck,
  input  logic [WORD_SIZE-1:0] ImemRData,
  output logic [WORD_SIZE-1:0] InstrD,
  output logic [WORD_SIZE-1:0] PCD,
  output logic [WORD_SIZE-1:0] PCPlus4D,
  output logic                 ValidD
);

  fetchState_t          state;
  fetchState_t          nextState;
  logic [WORD_SIZE-1:0] pcF;
  logic [WORD_SIZE-1:0] reqAddr;
  logic [WORD_SIZE-1:0] bufInstr;
  logic [WORD_SIZE-1:0] bufPC;
  ifIdReg_t             ifId;
  logic                 accept;
  logic                 holdRelease;

  assign ImemAddr = (state == IDLE) ? pcF : reqAddr;

  // Request strobe; withdrawn immediately while reset is held
  always_comb begin
    ImemReq = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    ImemReq = !StallF;
        WAIT:    ImemReq = 1'b1;
        DROP:    ImemReq = 1'b1;
        HOLD:    ImemReq = 1'b0;
        default: ImemReq = 1'b0;
      endcase
    end else begin
      ImemReq = 1'b0;
    end
  end

  // A redirect in the same cycle squashes whatever the memory returns
  assign accept = ImemReq && ImemAck && !PCSrcE && ((state == IDLE) || (state == WAIT));
  assign holdRelease = (state == HOLD) && !StallD && !FlushD && !PCSrcE;

  // Next-state logic of the fetch handshake FSM
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          nextState = (StallD && !FlushD) ? HOLD : IDLE;
        end else if (ImemReq && !ImemAck) begin
          // a redirect while the request is in flight must still drain it
          nextState = PCSrcE ? DROP : WAIT;
        end else begin
          nextState = IDLE;
        end
      end
      WAIT: begin
        if (PCSrcE) begin
          nextState = ImemAck ? IDLE : DROP;
        end else if (accept) begin
          nextState = (StallD && !FlushD) ? HOLD : IDLE;
        end else begin
          nextState = WAIT;
        end
      end
      DROP: begin
        if (ImemAck) begin
          nextState = IDLE;
        end else begin
          nextState = DROP;
        end
      end
      HOLD: begin
        if (PCSrcE || FlushD || !StallD) begin
          nextState = IDLE;
        end else begin
          nextState = HOLD;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // FSM state, fetch PC, outstanding address and the stalled-response buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pcF      <= alignWord(RESET_PC);
      reqAddr  <= 32'h0000_0000;
      bufInstr <= 32'h0000_0000;
      bufPC    <= 32'h0000_0000;
    end else begin
      state <= nextState;
      if (PCSrcE) begin
        pcF <= alignWord(PCTargetE);
      end else if (accept) begin
        pcF <= nextWord(pcF);
      end else begin
        pcF <= pcF;
      end
      if ((state == IDLE) && ImemReq && !ImemAck) begin
        reqAddr <= pcF;
      end
      if (accept && StallD && !FlushD) begin
        bufInstr <= ImemRData;
        bufPC    <= ImemAddr;
      end
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifId <= IFID_BUBBLE;
    end else if (FlushD) begin
      ifId <= IFID_BUBBLE;
    end else if (StallD) begin
      ifId <= ifId;
    end else if (holdRelease) begin
      ifId <= '{instr: bufInstr, pc: bufPC, pcPlus4: nextWord(bufPC), valid: 1'b1};
    end else if (accept) begin
      ifId <= '{instr: ImemRData, pc: ImemAddr, pcPlus4: nextWord(ImemAddr), valid: 1'b1};
    end else begin
      ifId <= IFID_BUBBLE;
    end
  end

  assign InstrD   = ifId.instr;
  assign PCD      = ifId.pc;
  assign PCPlus4D = ifId.pcPlus4;
  assign ValidD   = ifId.valid;

endmodule
